// File: rtl/audio_frame_scheduler_pkg.sv
// audio_frame_scheduler_pkg: shared bank/consumer state encodings and default frame length
package audio_frame_scheduler_pkg;
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FILLING = 2'b01,
    READING = 2'b10,
    FULL    = 2'b11
  } bank_state_e;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cons_state_e;
  localparam int DEFAULT_FRAME_LEN = 256;
endpackage

// File: rtl/audio_frame_scheduler_ram.sv
// audio_frame_scheduler_ram: two-bank frame RAM, one write port, one registered read port, no reset on contents
//  clk      in   sole clock
//  we       in   write enable
//  wr_addr  in   {bank, pointer} write address
//  wr_data  in   write data
//  rd_addr  in   {bank, address} read address
//  rd_data  out  data at rd_addr, one cycle later
module audio_frame_scheduler_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/audio_frame_scheduler.sv
// audio_frame_scheduler: packs mono samples into ping-pong frames and hands full frames to a consumer
//  S_AXIS_ACLK/S_AXIS_ARESET  clock, async active-high reset
//  enable                     accept samples; low discards the partial frame
//  mono_sample_valid/sample   incoming sample strobe and data
//  frame_start/frame_bank     one-cycle frame hand-off and the bank being handed over
//  frame_done                 consumer releases frame_bank
//  rd_addr/rd_data            consumer random-access read, one cycle latency
//  frame_pending              a full frame waits for the consumer
//  overrun_count              saturating count of dropped samples
module audio_frame_scheduler
  import audio_frame_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int ADDR_WIDTH = 8,
  parameter int OVR_WIDTH  = 16
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  input  logic                  enable,
  input  logic                  mono_sample_valid,
  input  logic [DATA_WIDTH-1:0] mono_sample,
  output logic                  frame_start,
  output logic                  frame_bank,
  input  logic                  frame_done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  frame_pending,
  output logic [OVR_WIDTH-1:0]  overrun_count
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);
  bank_state_e           bank_q [2];
  bank_state_e           bank_d [2];
  cons_state_e           cons_q, cons_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  frame_bank_q, frame_bank_d;
  logic [OVR_WIDTH-1:0]  ovr_q, ovr_d;
  logic                  full_sel, wr_ok, accept, release_bank;
  always_comb begin
    // at most one bank can be FULL, so full_sel names it whenever one exists
    full_sel      = bank_q[0] != FULL;
    frame_pending = bank_q[0] == FULL || bank_q[1] == FULL;
    frame_start   = cons_q == IDLE && frame_pending;
    frame_bank    = frame_start ? full_sel : frame_bank_q;
    wr_ok         = bank_q[wr_bank_q] == EMPTY || bank_q[wr_bank_q] == FILLING;
    accept        = enable && mono_sample_valid && wr_ok;
    release_bank  = cons_q == BUSY && frame_done;
    bank_d        = bank_q;
    wr_bank_d     = wr_bank_q;
    wr_ptr_d      = wr_ptr_q;
    frame_bank_d  = frame_bank;
    cons_d        = frame_start ? BUSY : release_bank ? IDLE : cons_q;
    ovr_d         = enable && mono_sample_valid && !wr_ok && ovr_q != '1 ? ovr_q + 1'b1 : ovr_q;
    // start, release and write each touch a bank in a different state, so they never collide
    if (frame_start) bank_d[full_sel] = READING;
    if (release_bank) bank_d[frame_bank_q] = EMPTY;
    if (accept) begin
      bank_d[wr_bank_q] = wr_ptr_q == LAST ? FULL : FILLING;
      wr_bank_d         = wr_ptr_q == LAST ? ~wr_bank_q : wr_bank_q;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end else if (!enable && bank_q[wr_bank_q] == FILLING) begin
      bank_d[wr_bank_q] = EMPTY;
      wr_ptr_d          = '0;
    end
  end
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      bank_q[0]    <= EMPTY;
      bank_q[1]    <= EMPTY;
      cons_q       <= IDLE;
      wr_bank_q    <= 1'b0;
      wr_ptr_q     <= '0;
      frame_bank_q <= 1'b0;
      ovr_q        <= '0;
    end else begin
      bank_q       <= bank_d;
      cons_q       <= cons_d;
      wr_bank_q    <= wr_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      frame_bank_q <= frame_bank_d;
      ovr_q        <= ovr_d;
    end
  end
  assign overrun_count = ovr_q;
  audio_frame_scheduler_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .AW        (ADDR_WIDTH + 1)
  ) u_ram (
    .clk    (S_AXIS_ACLK),
    .we     (accept),
    .wr_addr({wr_bank_q, wr_ptr_q}),
    .wr_data(mono_sample),
    .rd_addr({frame_bank, rd_addr}),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb_audio_frame_scheduler: directed checks of frame scheduling, reads, overrun and reset behaviour
module tb_audio_frame_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] sample = '0;
  logic        done = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic        frame_start, frame_bank, frame_pending;
  logic [31:0] rd_data;
  logic [15:0] ovr;
  logic        frame_start4, frame_bank4, frame_pending4;
  logic [31:0] rd_data4;
  logic [3:0]  ovr4;
  int          compared = 0;
  int          mismatched = 0;
  always #5 clk = ~clk;
  audio_frame_scheduler #(.DATA_WIDTH(32), .FRAME_LEN(8), .ADDR_WIDTH(3), .OVR_WIDTH(16)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .enable(enable), .mono_sample_valid(valid),
    .mono_sample(sample), .frame_start(frame_start), .frame_bank(frame_bank), .frame_done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_pending(frame_pending), .overrun_count(ovr)
  );
  audio_frame_scheduler #(.DATA_WIDTH(32), .FRAME_LEN(8), .ADDR_WIDTH(3), .OVR_WIDTH(4)) dut4 (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .enable(enable), .mono_sample_valid(valid),
    .mono_sample(sample), .frame_start(frame_start4), .frame_bank(frame_bank4), .frame_done(done),
    .rd_addr(rd_addr), .rd_data(rd_data4), .frame_pending(frame_pending4), .overrun_count(ovr4)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] v);
    valid  = 1'b1;
    sample = v;
    step();
    valid  = 1'b0;
  endtask
  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a);
    rd_addr = a;
    step();
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    check("rst_start", frame_start, 0);
    check("rst_bank", frame_bank, 0);
    check("rst_pending", frame_pending, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;
    step();
    enable = 1'b1;
    for (int i = 1; i <= 7; i++) send(i);
    check("t1_no_early_start", frame_start, 0);
    send(8);
    check("t1_start", frame_start, 1);
    check("t1_bank", frame_bank, 0);
    check("t1_pending", frame_pending, 1);
    step();
    check("t1_start_pulse", frame_start, 0);
    check("t1_pending_clr", frame_pending, 0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check($sformatf("t1_rd%0d", a), rd_data, 64'(a + 1));
    end
    for (int i = 9; i <= 16; i++) send(i);
    check("t2_pending", frame_pending, 1);
    check("t2_no_start_busy", frame_start, 0);
    for (int i = 0; i < 8; i++) send(100 + i);
    check("t2_ovr", ovr, 8);
    check("t2_ovr4", ovr4, 8);
    pulse_done();
    check("t2_start", frame_start, 1);
    check("t2_bank", frame_bank, 1);
    step();
    check("t2_bank_hold", frame_bank, 1);
    rd(0);
    check("t2_rd0", rd_data, 9);
    rd(7);
    check("t2_rd7", rd_data, 16);
    for (int i = 30; i <= 36; i++) send(i);
    done = 1'b1;
    send(37);
    done = 1'b0;
    check("t3_start", frame_start, 1);
    check("t3_bank", frame_bank, 0);
    send(38);
    check("t3_start_pulse", frame_start, 0);
    check("t3_bank_hold", frame_bank, 0);
    rd(7);
    check("t3_rd7", rd_data, 37);
    rd(0);
    check("t3_rd0", rd_data, 30);
    for (int i = 39; i <= 45; i++) send(i);
    check("t3_pending", frame_pending, 1);
    pulse_done();
    check("t3_start_b1", frame_start, 1);
    check("t3_bank_b1", frame_bank, 1);
    step();
    rd(0);
    check("t3_b1_addr0", rd_data, 38);
    rd(7);
    check("t3_b1_addr7", rd_data, 45);
    for (int i = 50; i <= 54; i++) send(i);
    enable = 1'b0;
    step();
    send(99);
    enable = 1'b1;
    for (int i = 20; i <= 27; i++) send(i);
    check("t4_pending", frame_pending, 1);
    pulse_done();
    check("t4_start", frame_start, 1);
    check("t4_bank", frame_bank, 0);
    step();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check($sformatf("t4_rd%0d", a), rd_data, 64'(20 + a));
    end
    check("t4_ovr", ovr, 8);
    for (int i = 60; i <= 63; i++) send(i);
    rst = 1'b1;
    #1;
    check("t5_start", frame_start, 0);
    check("t5_bank", frame_bank, 0);
    check("t5_pending", frame_pending, 0);
    check("t5_ovr", ovr, 0);
    step();
    rst = 1'b0;
    step();
    for (int i = 70; i <= 76; i++) send(i);
    check("t5_no_start", frame_start, 0);
    check("t5_no_pending", frame_pending, 0);
    send(77);
    check("t5_start_new", frame_start, 1);
    check("t5_bank_new", frame_bank, 0);
    step();
    rd(0);
    check("t5_rd0", rd_data, 70);
    for (int i = 80; i <= 87; i++) send(i);
    check("t6_pending", frame_pending, 1);
    for (int i = 0; i < 20; i++) begin
      send(200 + i);
      if (i == 13) check("t6_ovr4_14", ovr4, 14);
    end
    check("t6_ovr4_sat", ovr4, 15);
    check("t6_ovr16", ovr, 20);
    pulse_done();
    check("t6_start", frame_start, 1);
    check("t6_bank", frame_bank, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
